// File: rtl/aes_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// aes_ctrl_pkg
// Shared types and helpers for the iterative AES round controller:
//   state_t     controller FSM states (IDLE, ROUND, HOLD)
//   RCON_INIT   first round constant
//   RCON_POLY   AES field reduction byte (x^8 = x^4 + x^3 + x + 1)
//   NR_DEFAULT  AES-128 round count
//   xtime()     multiply by x in GF(2^8)
// ---------------------------------------------------------------------------
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] RCON_POLY  = 8'h1B;
    localparam int         NR_DEFAULT = 10;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl_if
// Host-side handshake bundle of the AES round controller.
//   in_valid / in_ready   : block request handshake (host -> controller)
//   out_valid / out_ready : result handshake (controller -> host)
//   abort                 : discard the block in flight
// modport master : host side, slave : controller side.
// ---------------------------------------------------------------------------
interface aes_round_ctrl_if;

    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic abort;

    modport master (
        output in_valid,
        output out_ready,
        output abort,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        input  abort,
        output in_ready,
        output out_valid
    );

endinterface

// File: rtl/aes_rcon_gen.sv
// ---------------------------------------------------------------------------
// aes_rcon_gen
// Round-constant register for the on-the-fly key schedule.
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset (rcon <- 0x00)
//   load   : rcon <- 0x01
//   step   : rcon <- xtime(rcon)
//   clear  : rcon <- 0x00 (highest priority)
//   rcon   : current round constant
// ---------------------------------------------------------------------------
module aes_rcon_gen
    import aes_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    input  logic       clear,
    output logic [7:0] rcon
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcon <= 8'h00;
        end else if (clear) begin
            rcon <= 8'h00;
        end else if (load) begin
            rcon <= RCON_INIT;
        end else if (step) begin
            rcon <= xtime(rcon);
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// Iterative AES encryption round controller. Accepts one block, drives the
// initial AddRoundKey load, NR round strobes with round index and round
// constant, then holds the result valid until accepted. Carries no data.
// Parameters:
//   NR     number of rounds, legal 1..14 (4-bit round counter)
//   CNT_W  width of the completed-block counter
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-low reset
//   host          handshake bundle (in_valid/in_ready, out_valid/out_ready,
//                 abort)
//   dp_load       datapath captures plaintext ^ key (combinational)
//   dp_round_en   datapath performs one round
//   dp_final      last round, datapath skips MixColumns
//   ks_load       key schedule captures cipher key (combinational)
//   ks_step       key schedule advances one round key
//   rcon          round constant for the current ks_step
//   round         current round index, 0 outside ROUND
//   busy          a block is in flight
//   done_cnt      number of results accepted (wraps)
// ---------------------------------------------------------------------------
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NR    = NR_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    aes_round_ctrl_if.slave  host,
    output logic             dp_load,
    output logic             dp_round_en,
    output logic             dp_final,
    output logic             ks_load,
    output logic             ks_step,
    output logic [7:0]       rcon,
    output logic [3:0]       round,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    localparam logic [3:0] NR_L = 4'(NR);

    state_t state;
    logic   round_en_q;
    logic   final_q;
    logic   out_valid_q;
    logic   busy_q;

    logic   accept;
    logic   last_round;
    logic   rcon_load;
    logic   rcon_step;
    logic   rcon_clear;

    // Accept is decoded from the registered state so dp_load/ks_load land
    // in the handshake cycle itself.
    assign accept      = (state == IDLE) && host.in_valid;
    assign last_round  = (state == ROUND) && (round == NR_L);

    assign host.in_ready  = (state == IDLE);
    assign host.out_valid = out_valid_q;
    assign dp_load        = accept;
    assign ks_load        = accept;
    assign dp_round_en    = round_en_q;
    assign ks_step        = round_en_q;
    assign dp_final       = final_q;
    assign busy           = busy_q;

    // rcon leaves ROUND cleared so it reads 0 whenever ks_step is low.
    assign rcon_load  = accept;
    assign rcon_step  = (state == ROUND) && !host.abort && !last_round;
    assign rcon_clear = (state == ROUND) && (host.abort || last_round);

    aes_rcon_gen u_rcon_gen (
        .clk   (clk),
        .rst   (rst),
        .load  (rcon_load),
        .step  (rcon_step),
        .clear (rcon_clear),
        .rcon  (rcon)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            round       <= 4'd0;
            round_en_q  <= 1'b0;
            final_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // abort is meaningless here; a request is still taken
                    if (host.in_valid) begin
                        state      <= ROUND;
                        round      <= 4'd1;
                        round_en_q <= 1'b1;
                        final_q    <= (NR_L == 4'd1);
                        busy_q     <= 1'b1;
                    end
                end
                ROUND: begin
                    if (host.abort) begin
                        state      <= IDLE;
                        round      <= 4'd0;
                        round_en_q <= 1'b0;
                        final_q    <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (round == NR_L) begin
                        state       <= HOLD;
                        round       <= 4'd0;
                        round_en_q  <= 1'b0;
                        final_q     <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        round   <= round + 4'd1;
                        final_q <= ((round + 4'd1) == NR_L);
                    end
                end
                HOLD: begin
                    // abort wins over a same-cycle out_ready
                    if (host.abort) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (host.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_cnt    <= done_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    round       <= 4'd0;
                    round_en_q  <= 1'b0;
                    final_q     <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule
